// File: rtl/seg7_pkg.sv
// Shared constants for the 7-segment scan driver: active-low segment codes
// and the "everything off" patterns for segments and anodes.
package seg7_pkg;

  localparam logic [6:0] SEG_OFF = 7'h7F;
  localparam logic [3:0] AN_OFF  = 4'hF;

  // Active-low {g,f,e,d,c,b,a} for hex digits 0..F
  localparam logic [6:0] SEG_CODE [16] = '{
    7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
    7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E
  };

endpackage

// File: rtl/seg7_scan_driver_hex_to_seg.sv
// Combinational hex nibble to active-low segment decoder with a blanking
// override that forces every segment dark.
module hex_to_seg
  import seg7_pkg::*;
(
  input  logic [3:0] nibble,
  input  logic       blank,
  output logic [6:0] seg
);

  assign seg = blank ? SEG_OFF : SEG_CODE[nibble];

endmodule

// File: rtl/seg7_scan_driver.sv
// Time-multiplexed 4-digit common-anode display driver: frame-latched value,
// per-slot anti-ghost blanking, leading-zero suppression and decimal points.
module seg7_scan_driver
  import seg7_pkg::*;
#(
  parameter int REFRESH_DIV  = 100000,
  parameter int BLANK_CYCLES = 1000,
  parameter int LZ_BLANK     = 1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [15:0] value,
  input  logic [3:0]  dp_mask,
  input  logic        enable,
  output logic [3:0]  an,
  output logic [6:0]  seg,
  output logic        dp,
  output logic        frame_done
);

  localparam int CW = $clog2(REFRESH_DIV);

  logic [CW-1:0] cnt_q, cnt_d;
  logic [1:0]    idx_q, idx_d;
  logic [15:0]   shadow_q, shadow_d;
  logic [3:0]    dp_sh_q, dp_sh_d;
  logic          first_q, first_d;
  logic [3:0]    an_q, an_d;
  logic [6:0]    seg_q, seg_d;
  logic          dp_q, dp_d;
  logic          fd_q, fd_d;

  logic          wrap;
  logic [3:0]    nib;
  logic          lz_dark;
  logic          lit;

  // Slot timing and frame-boundary shadow capture
  always_comb begin
    wrap     = (cnt_q == CW'(REFRESH_DIV - 1));
    cnt_d    = cnt_q;
    idx_d    = idx_q;
    shadow_d = shadow_q;
    dp_sh_d  = dp_sh_q;
    first_d  = first_q;
    fd_d     = 1'b0;
    if (enable) begin
      cnt_d = wrap ? '0 : cnt_q + CW'(1);
      if (wrap) idx_d = idx_q + 2'd1;
      fd_d = wrap && (idx_q == 2'd3);
      if ((wrap && (idx_q == 2'd3)) || first_q) begin
        shadow_d = value;
        dp_sh_d  = dp_mask;
        first_d  = 1'b0;
      end
    end
  end

  // Digit selection; a digit is dark when it and every digit to its left are zero
  always_comb begin
    nib     = shadow_q[3:0];
    lz_dark = 1'b0;
    case (idx_q)
      2'd0: nib = shadow_q[3:0];
      2'd1: begin nib = shadow_q[7:4];   lz_dark = (shadow_q[15:4]  == 12'h000); end
      2'd2: begin nib = shadow_q[11:8];  lz_dark = (shadow_q[15:8]  == 8'h00);   end
      2'd3: begin nib = shadow_q[15:12]; lz_dark = (shadow_q[15:12] == 4'h0);    end
      default: ;
    endcase
    if (LZ_BLANK == 0) lz_dark = 1'b0;
    lit  = enable && (cnt_q >= CW'(BLANK_CYCLES)) && !lz_dark;
    an_d = lit ? ~(4'b0001 << idx_q) : AN_OFF;
    dp_d = lit ? ~dp_sh_q[idx_q] : 1'b1;
  end

  hex_to_seg u_hex_to_seg (
    .nibble (nib),
    .blank  (!lit),
    .seg    (seg_d)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt_q    <= '0;
      idx_q    <= 2'd0;
      shadow_q <= 16'h0000;
      dp_sh_q  <= 4'h0;
      first_q  <= 1'b1;
      an_q     <= AN_OFF;
      seg_q    <= SEG_OFF;
      dp_q     <= 1'b1;
      fd_q     <= 1'b0;
    end else begin
      cnt_q    <= cnt_d;
      idx_q    <= idx_d;
      shadow_q <= shadow_d;
      dp_sh_q  <= dp_sh_d;
      first_q  <= first_d;
      an_q     <= an_d;
      seg_q    <= seg_d;
      dp_q     <= dp_d;
      fd_q     <= fd_d;
    end
  end

  assign an         = an_q;
  assign seg        = seg_q;
  assign dp         = dp_q;
  assign frame_done = fd_q;

endmodule

// File: tb/tb_seg7_scan_driver.sv
// Bench for seg7_scan_driver: frame-position model compared every cycle plus
// directed literal expectations for each display feature.
module tb_seg7_scan_driver;

  localparam int DIV   = 8;
  localparam int BLK   = 2;
  localparam int FRAME = 4 * DIV;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        enable;
  logic [15:0] value;
  logic [3:0]  dp_mask;
  logic [3:0]  an;
  logic [6:0]  seg;
  logic        dp;
  logic        frame_done;

  always #5 clk = ~clk;

  seg7_scan_driver #(
    .REFRESH_DIV  (DIV),
    .BLANK_CYCLES (BLK),
    .LZ_BLANK     (1)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .value      (value),
    .dp_mask    (dp_mask),
    .enable     (enable),
    .an         (an),
    .seg        (seg),
    .dp         (dp),
    .frame_done (frame_done)
  );

  int n_total = 0;
  int n_pass  = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
  endtask

  // Reference model: position within a 32-cycle frame plus the latched word
  logic [6:0] hex_tab [16] = '{
    7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
    7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E
  };
  int          m_pos  = 0;
  int          m_last = -1;
  logic [15:0] m_sh   = 16'h0;
  logic [3:0]  m_dsh  = 4'h0;
  bit          m_first = 1'b1;
  logic [3:0]  e_an  = 4'hF;
  logic [6:0]  e_seg = 7'h7F;
  logic        e_dp  = 1'b1;
  logic        e_fd  = 1'b0;

  always @(posedge clk) begin : model
    int   slot;
    int   ph;
    bit   shown;
    logic [3:0] nb;
    if (!rst_n) begin
      m_pos = 0; m_last = -1; m_sh = 16'h0; m_dsh = 4'h0; m_first = 1'b1;
      e_an = 4'hF; e_seg = 7'h7F; e_dp = 1'b1; e_fd = 1'b0;
    end else if (!enable) begin
      m_last = -1;
      e_an = 4'hF; e_seg = 7'h7F; e_dp = 1'b1; e_fd = 1'b0;
    end else begin
      slot  = m_pos / DIV;
      ph    = m_pos % DIV;
      nb    = m_sh[4*slot +: 4];
      shown = (slot == 0) || ((m_sh >> (4 * slot)) != 16'h0);
      if (ph >= BLK && shown) begin
        e_an  = 4'hF ^ (4'b0001 << slot);
        e_seg = hex_tab[nb];
        e_dp  = ~m_dsh[slot];
      end else begin
        e_an = 4'hF; e_seg = 7'h7F; e_dp = 1'b1;
      end
      e_fd = (m_pos == FRAME - 1);
      if (m_pos == FRAME - 1 || m_first) begin
        m_sh = value; m_dsh = dp_mask; m_first = 1'b0;
      end
      m_last = m_pos;
      m_pos  = (m_pos + 1) % FRAME;
    end
  end

  bit chk_en = 1'b0;

  always @(negedge clk) begin
    if (chk_en) begin
      check("model_an",  an,         e_an);
      check("model_seg", seg,        e_seg);
      check("model_dp",  dp,         e_dp);
      check("model_fd",  frame_done, e_fd);
    end
  end

  task automatic step();
    @(negedge clk);
  endtask

  task automatic goto(input int p);
    int n = 0;
    while (m_pos != p && n < 100) begin
      step();
      n++;
    end
    if (m_pos != p) check("goto_timeout", m_pos, p);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1, "watchdog");
  end

  logic [3:0] an_t  [4] = '{4'hE, 4'hD, 4'hB, 4'h7};
  logic [6:0] seg_t [4] = '{7'h12, 7'h08, 7'h40, 7'h0E};

  initial begin
    int fdcnt;
    int p;
    int s;
    int ph;
    rst_n = 1'b0; enable = 1'b1; value = 16'h1234; dp_mask = 4'h0;
    @(negedge clk);
    chk_en = 1'b1;

    repeat (3) begin
      check("rst_an",  an,         4'hF);
      check("rst_seg", seg,        7'h7F);
      check("rst_dp",  dp,         1'b1);
      check("rst_fd",  frame_done, 1'b0);
      step();
    end

    // Basic scan of F0A5
    rst_n = 1'b1; value = 16'hF0A5; dp_mask = 4'h0;
    fdcnt = 0;
    for (int k = 0; k < 2 * FRAME; k++) begin
      step();
      p = k % FRAME; s = p / DIV; ph = p % DIV;
      if (ph < BLK) check("scan_blank_an", an, 4'hF);
      if (ph == BLK) begin
        check("scan_an",  an,  an_t[s]);
        check("scan_seg", seg, seg_t[s]);
      end
      if (p == FRAME - 1) check("scan_fd_at_end", frame_done, 1'b1);
      if (frame_done) fdcnt++;
    end
    check("scan_fd_count", fdcnt, 2);

    // Tear-free latching
    value = 16'h1111;
    goto(FRAME - 1); step();
    goto(10);
    value = 16'h2222;
    repeat (22) begin
      step();
      if (m_last % DIV >= BLK) check("tear_old_seg", seg, 7'h79);
    end
    repeat (FRAME) begin
      step();
      if (m_last % DIV >= BLK) check("tear_new_seg", seg, 7'h24);
    end

    // Leading-zero suppression
    value = 16'h0003;
    goto(FRAME - 1); step();
    repeat (FRAME) begin
      step();
      s = m_last / DIV; ph = m_last % DIV;
      if (ph >= BLK && s == 0) begin
        check("lz3_seg", seg, 7'h30);
        check("lz3_an",  an,  4'hE);
      end else if (s != 0) begin
        check("lz3_dark_an",  an,  4'hF);
        check("lz3_dark_seg", seg, 7'h7F);
      end
    end
    value = 16'h0000;
    goto(FRAME - 1); step();
    repeat (FRAME) begin
      step();
      s = m_last / DIV; ph = m_last % DIV;
      if (ph >= BLK && s == 0) check("lz0_seg", seg, 7'h40);
      if (s == 3) check("lz0_dark_an", an, 4'hF);
    end

    // Decimal point on digit 2 only
    value = 16'h8888; dp_mask = 4'b0100;
    goto(FRAME - 1); step();
    repeat (FRAME) begin
      step();
      s = m_last / DIV; ph = m_last % DIV;
      check("dp_pin", dp, (s == 2 && ph >= BLK) ? 1'b0 : 1'b1);
    end

    // Enable dropped in the digit2 slot, then resumed
    goto(18);
    enable = 1'b0;
    step();
    check("dis_an",  an,  4'hF);
    check("dis_seg", seg, 7'h7F);
    check("dis_dp",  dp,  1'b1);
    repeat (4) begin
      step();
      check("dis_fd", frame_done, 1'b0);
      check("dis_an_hold", an, 4'hF);
    end
    enable = 1'b1;
    step();
    check("resume_an",  an,  4'hB);
    check("resume_seg", seg, 7'h00);
    check("resume_dp",  dp,  1'b0);

    // Reset pulse mid-frame
    value = 16'hABCD; dp_mask = 4'h0;
    goto(13);
    rst_n = 1'b0;
    step();
    check("midrst_an",  an,         4'hF);
    check("midrst_seg", seg,        7'h7F);
    check("midrst_fd",  frame_done, 1'b0);
    rst_n = 1'b1;
    step();
    check("restart_blank_an", an, 4'hF);
    step(); step();
    check("restart_an",  an,  4'hE);
    check("restart_seg", seg, 7'h21);
    repeat (40) step();

    chk_en = 1'b0;
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/seg7_scan_driver.md
Name: seg7_scan_driver

Overview:
- Downstream consumer of the 16-bit memory read word (`out` of the memory board stage).
- Displays the word as 4 hex digits on a common-anode, time-multiplexed 7-segment display.
- Provides tear-free frame latching, anti-ghosting blanking, leading-zero suppression and per-digit decimal points.

Parameters:
- REFRESH_DIV, 100000: clk cycles per digit slot (1 ms at 100 MHz). Legal range ≥ 4.
- BLANK_CYCLES, 1000: cycles at the start of each slot with all anodes off. Must satisfy BLANK_CYCLES < REFRESH_DIV.
- LZ_BLANK, 1: 1 = suppress leading zero digits; 0 = show all four digits.

Ports:
- clk  input  1  system clock, rising edge
- rst_n  input  1  synchronous active-low reset
- value  input  16  word to display; digit0 = value[3:0] (rightmost), digit3 = value[15:12]
- dp_mask  input  4  decimal point request per digit, 1 = lit
- enable  input  1  1 = display active; 0 = dark
- an  output  4  anode selects, active-low, an[i] drives digit i
- seg  output  7  segments {g,f,e,d,c,b,a}, active-low
- dp  output  1  decimal point, active-low
- frame_done  output  1  one-cycle pulse when digit3 slot ends

Behaviour:
- Clock and reset: one clock, `clk`. Reset is synchronous and active-low on `rst_n`.
- Reset values:
  - an = 4'b1111, seg = 7'b1111111, dp = 1, frame_done = 0.
  - Slot counter = 0, digit index = 0, shadow register = 16'h0000, dp shadow = 0.
- Slot counter:
  - Counts 0..REFRESH_DIV-1 while enable = 1, then wraps to 0.
  - On wrap, the digit index advances 0→1→2→3→0.
- Shadow latch:
  - value and dp_mask are captured into shadow registers on the cycle where the counter wraps with index = 3 (the frame boundary).
  - They are also captured on the first enabled cycle after reset.
  - Mid-frame changes to value are never visible until the next frame.
- frame_done:
  - Asserted for exactly one cycle, in the same cycle as the index 3→0 wrap.
- Blanking window:
  - While counter < BLANK_CYCLES, an = 4'b1111.
  - Otherwise an = ~(4'b0001 << index).
- Registered outputs: an, seg and dp are registered, so they reflect the counter/index state one cycle later. Latency from a slot-counter change to the pin is 1 clk.
- Hex decode (active-low gfedcba):
  - 0=40, 1=79, 2=24, 3=30, 4=19, 5=12, 6=02, 7=78
  - 8=00, 9=10, A=08, b=03, C=46, d=21, E=06, F=0E
- Leading-zero suppression (LZ_BLANK = 1):
  - Digit i (i = 3..1) is dark (seg = 7F, an stays off) when shadow nibbles i..3 are all zero.
  - Digit 0 is always shown. 16'h0000 therefore displays a single "0".
  - dp_mask does not override suppression.
- dp output: dp = ~dp_shadow[index] during the lit window; 1 otherwise.
- enable = 0:
  - Next cycle: an = 4'b1111, seg = 7F, dp = 1.
  - Counter and index are held; no frame_done pulses.
  - On re-enable, scanning resumes from the held state.
- rst_n low mid-frame: all state returns to reset values on the next edge. rst_n has priority over enable.
- Width rule: the counter is sized $clog2(REFRESH_DIV) bits; no other arithmetic.

Decomposition:
- Shared package `seg7_pkg`:
  - SEG_CODE constant array (16 × 7-bit, values above).
  - SEG_OFF = 7'h7F and AN_OFF = 4'hF.
- Sub-module `hex_to_seg`:
  - Purely combinational.
  - Inputs: nibble, blank. Output: 7-bit seg.
  - Instantiated once in the output mux path.
- Top level holds the counter, index, shadow registers and output registers.

Test Plan:
All scenarios use REFRESH_DIV = 8 and BLANK_CYCLES = 2.
- Reset: hold rst_n = 0 for 3 cycles with value = 16'h1234 → an = F, seg = 7F, dp = 1, frame_done = 0 throughout.
- Basic scan: value = 16'hF0A5, dp_mask = 0 → digit slots in order show:
  - an = E, seg = 12; then an = D, seg = 08; then an = B, seg = 40; then an = 7, seg = 0E.
  - Within each 8-cycle slot, an = F for the first 2 cycles.
  - frame_done pulses once every 32 cycles.
- Tear-free latch: change value from 16'h1111 to 16'h2222 during the digit1 slot → the remainder of that frame still shows 79. The next frame shows 24 on all digits.
- Leading zeros: value = 16'h0003 → only digit0 lit (seg = 30); an stays F in slots 1-3. value = 16'h0000 → digit0 shows 40.
- Decimal point: dp_mask = 4'b0100, value = 16'h8888 → dp = 0 only during the lit window of the digit2 slot.
- Enable/reset mid-frame:
  - Drop enable in the digit2 slot → outputs dark next cycle; resumes at digit2 with the same counter value.
  - Pulse rst_n low mid-frame → restarts at digit0 with shadow = 0 until the next capture.
